// File: rtl/color_classifier_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : color_classifier_if                                           |
// | Brief    : Count-sample stream from the colour-sensor frequency stage.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface color_classifier_if #(
    parameter int CNT_W = 32
);
    logic             cnt_valid;
    logic [1:0]       cnt_chan;
    logic [CNT_W-1:0] cnt_value;

    modport master (output cnt_valid, cnt_chan, cnt_value);
    modport slave  (input  cnt_valid, cnt_chan, cnt_value);
endinterface
`default_nettype wire

// File: rtl/color_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : color_classifier                                              |
// | Brief    : Frame assembly, R/B/G classification and debounced colour.    |
// |            Optional macro CLEAR_GATE_EN: dark frames classify as none.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module color_classifier #(
    parameter int CNT_W     = 32,
    parameter int RED_MAX   = 24,
    parameter int BLUE_MAX  = 21,
    parameter int GREEN_MAX = 19,
    parameter int STABLE_N  = 3,
    parameter int CLEAR_MIN = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    color_classifier_if.slave  cnt,
    output logic [2:0]         color,
    output logic               color_changed,
    output logic               raw_valid,
    output logic [2:0]         raw_class,
    output logic               frame_err
);

    typedef enum logic [1:0] {
        S_COLLECT  = 2'd0,
        S_CLASSIFY = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    localparam logic [1:0]       c_ch_red    = 2'b00;
    localparam logic [1:0]       c_ch_blue   = 2'b01;
    localparam logic [1:0]       c_ch_green  = 2'b11;
    localparam logic [1:0]       c_ch_clear  = 2'b10;
    localparam logic [CNT_W-1:0] c_red_max   = CNT_W'(RED_MAX);
    localparam logic [CNT_W-1:0] c_blue_max  = CNT_W'(BLUE_MAX);
    localparam logic [CNT_W-1:0] c_green_max = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] c_clear_min = CNT_W'(CLEAR_MIN);
    localparam logic [3:0]       c_stable    = 4'(STABLE_N);
`ifdef CLEAR_GATE_EN
    localparam logic             c_gate_en   = 1'b1;
`else
    localparam logic             c_gate_en   = 1'b0;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_red;
    logic [CNT_W-1:0] r_blue;
    logic [CNT_W-1:0] r_green;
    logic [2:0]       r_have;     // {G, B, R}
    logic [2:0]       r_pend;     // next-frame samples seen while busy
    logic [2:0]       r_cand;
    logic [3:0]       r_agree;

    logic       w_is_clear;
    logic [2:0] w_ch_bit;
    logic       w_frame_ok;
    logic       w_frame_bad;
    logic       w_dark;
    logic       w_red_win;
    logic       w_blue_win;
    logic       w_green_win;
    logic [2:0] w_raw;

    assign w_is_clear  = cnt.cnt_valid && (cnt.cnt_chan == c_ch_clear);
    assign w_frame_ok  = w_is_clear && (r_state == S_COLLECT) && (&r_have);
    assign w_frame_bad = w_is_clear && (r_state == S_COLLECT) && !(&r_have);

    always_comb begin
        w_ch_bit = 3'b000;
        if (cnt.cnt_valid) begin
            case (cnt.cnt_chan)
                c_ch_red:   w_ch_bit = 3'b001;
                c_ch_blue:  w_ch_bit = 3'b010;
                c_ch_green: w_ch_bit = 3'b100;
                default:    w_ch_bit = 3'b000;
            endcase
        end
    end

    // The clear count is judged as it arrives, since the frame is classified on that same edge.
    assign w_dark      = c_gate_en && (cnt.cnt_value < c_clear_min);
    assign w_red_win   = (r_red < r_blue) && (r_red < r_green) && (r_red < c_red_max);
    assign w_blue_win  = (r_blue < r_red) && (r_blue < r_green) && (r_blue < c_blue_max);
    assign w_green_win = (r_green < r_red) && (r_green < r_blue) && (r_green < c_green_max);

    always_comb begin
        w_raw = 3'b000;
        if (!w_dark) begin
            if (w_red_win)        w_raw = 3'b001;
            else if (w_blue_win)  w_raw = 3'b010;
            else if (w_green_win) w_raw = 3'b100;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_COLLECT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_COLLECT:  if (w_frame_ok) w_next = S_CLASSIFY;
            S_CLASSIFY: w_next = S_UPDATE;
            S_UPDATE:   w_next = S_COLLECT;
            default:    w_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_red         <= '0;
            r_blue        <= '0;
            r_green       <= '0;
            r_have        <= 3'b000;
            r_pend        <= 3'b000;
            r_cand        <= 3'b000;
            r_agree       <= 4'd0;
            color         <= 3'b000;
            color_changed <= 1'b0;
            raw_valid     <= 1'b0;
            raw_class     <= 3'b000;
            frame_err     <= 1'b0;
        end else begin
            color_changed <= 1'b0;
            raw_valid     <= 1'b0;
            frame_err     <= 1'b0;
            if (w_ch_bit[0]) r_red   <= cnt.cnt_value;
            if (w_ch_bit[1]) r_blue  <= cnt.cnt_value;
            if (w_ch_bit[2]) r_green <= cnt.cnt_value;
            case (r_state)
                S_COLLECT: begin
                    r_have <= r_have | w_ch_bit;
                    if (w_frame_bad) begin
                        frame_err <= 1'b1;
                        r_have    <= 3'b000;
                    end
                    if (w_frame_ok) begin
                        raw_class <= w_raw;
                        raw_valid <= 1'b1;
                        if (w_raw == r_cand) begin
                            r_agree <= (r_agree == c_stable) ? r_agree : r_agree + 4'd1;
                        end else begin
                            r_cand  <= w_raw;
                            r_agree <= 4'd1;
                        end
                    end
                end
                S_CLASSIFY: begin
                    r_pend <= r_pend | w_ch_bit;
                    if ((r_agree == c_stable) && (r_cand != color)) begin
                        color         <= r_cand;
                        color_changed <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_have <= r_pend | w_ch_bit;
                    r_pend <= 3'b000;
                end
                default: r_have <= 3'b000;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_color_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_color_classifier                                           |
// | Brief    : Directed frames against a frame-level model of the classifier.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_color_classifier;

    localparam int CNT_W     = 32;
    localparam int RED_MAX   = 24;
    localparam int BLUE_MAX  = 21;
    localparam int GREEN_MAX = 19;
    localparam int STABLE_N  = 3;
    localparam int CLEAR_MIN = 8;

    localparam logic [1:0] R = 2'b00, B = 2'b01, G = 2'b11, C = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] color, raw_class;
    logic       color_changed, raw_valid, frame_err;

    color_classifier_if #(.CNT_W(CNT_W)) cnt_if ();

    color_classifier #(
        .CNT_W(CNT_W), .RED_MAX(RED_MAX), .BLUE_MAX(BLUE_MAX),
        .GREEN_MAX(GREEN_MAX), .STABLE_N(STABLE_N), .CLEAR_MIN(CLEAR_MIN)
    ) dut (
        .clk(clk), .rst(rst), .cnt(cnt_if),
        .color(color), .color_changed(color_changed),
        .raw_valid(raw_valid), .raw_class(raw_class), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model: expected pulses keyed by the cycle they must appear in.
    logic [31:0] m_val [4];
    bit   [2:0]  m_have;
    logic [2:0]  m_cand, m_color;
    int          m_agree, m_busy_end;
    logic [2:0]  exp_rv [int];
    bit          exp_fe [int];
    logic [2:0]  exp_cc [int];
    bit          exp_rst[int];

    logic [2:0] cur_color = 3'b000, cur_raw = 3'b000, last_raw = 3'b000;
    int n_changed = 0, n_rv = 0, n_fe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] classify(input logic [31:0] r, b, g, input logic [31:0] clr);
        logic [31:0] v[3];
        int          lim[3];
        logic [2:0]  code[3];
        int          win, nmin;
        v[0] = r; v[1] = b; v[2] = g;
        lim[0] = RED_MAX; lim[1] = BLUE_MAX; lim[2] = GREEN_MAX;
        code[0] = 3'b001; code[1] = 3'b010; code[2] = 3'b100;
`ifdef CLEAR_GATE_EN
        if (clr < 32'(CLEAR_MIN)) return 3'b000;
`else
        if (clr == 32'hx) return 3'b000;
`endif
        win = 0;
        for (int i = 1; i < 3; i++) if (v[i] < v[win]) win = i;
        nmin = 0;
        for (int i = 0; i < 3; i++) if (v[i] == v[win]) nmin++;
        if (nmin > 1 || v[win] >= 32'(lim[win])) return 3'b000;
        return code[win];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_val[i] = '0;
        m_have = 3'b000; m_cand = 3'b000; m_color = 3'b000;
        m_agree = 0; m_busy_end = 0;
        exp_rv.delete(); exp_fe.delete(); exp_cc.delete(); exp_rst.delete();
    endtask

    task automatic model_sample(input logic [1:0] ch, input logic [31:0] v, input int c);
        logic [2:0] raw;
        if (ch != C) begin
            m_val[ch] = v;
            m_have[(ch == R) ? 0 : (ch == B) ? 1 : 2] = 1'b1;
        end else if (c >= m_busy_end) begin
            if (&m_have) begin
                raw = classify(m_val[R], m_val[B], m_val[G], v);
                exp_rv[c + 1] = raw;
                if (raw == m_cand) m_agree = (m_agree < STABLE_N) ? m_agree + 1 : STABLE_N;
                else begin m_cand = raw; m_agree = 1; end
                if (m_agree == STABLE_N && m_cand != m_color) begin
                    m_color = m_cand;
                    exp_cc[c + 2] = m_cand;
                end
                m_busy_end = c + 3;
            end else begin
                exp_fe[c + 1] = 1'b1;
            end
            m_have = 3'b000;
        end
    endtask

    task automatic send(input logic [1:0] ch, input logic [31:0] v);
        @(negedge clk);
        cnt_if.cnt_valid = 1'b1;
        cnt_if.cnt_chan  = ch;
        cnt_if.cnt_value = v;
        model_sample(ch, v, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cnt_if.cnt_valid = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] r, b, g, clr);
        send(R, r); send(B, b); send(G, g); send(C, clr);
        idle(2);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        cnt_if.cnt_valid = 1'b0;
        model_reset();
        exp_rst[cyc + 1] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_rst.exists(cyc)) begin cur_color = 3'b000; cur_raw = 3'b000; end
        if (exp_rv.exists(cyc))  cur_raw   = exp_rv[cyc];
        if (exp_cc.exists(cyc))  cur_color = exp_cc[cyc];
        chk("raw_valid",     32'(raw_valid),     32'(exp_rv.exists(cyc)));
        chk("raw_class",     32'(raw_class),     32'(cur_raw));
        chk("frame_err",     32'(frame_err),     32'(exp_fe.exists(cyc)));
        chk("color_changed", 32'(color_changed), 32'(exp_cc.exists(cyc)));
        chk("color",         32'(color),         32'(cur_color));
        if (raw_valid)     begin last_raw = raw_class; n_rv++; end
        if (color_changed) n_changed++;
        if (frame_err)     n_fe++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cnt_if.cnt_valid = 1'b0;
        cnt_if.cnt_chan  = 2'b00;
        cnt_if.cnt_value = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset between samples leaves only G and clear in the frame.
        send(R, 10); send(B, 30);
        pulse_reset();
        send(G, 5); send(C, 50); idle(2);
        chk("lit_reset_frame_err", 32'(n_fe), 32'd1);
        chk("lit_reset_no_raw",    32'(n_rv), 32'd0);

        frame(10, 30, 40, 50);
        chk("lit_red1_color", 32'(color), 32'd0);
        frame(10, 30, 40, 50);
        chk("lit_red2_color", 32'(color), 32'd0);
        frame(10, 30, 40, 50);
        chk("lit_red3_color",   32'(color),     32'b001);
        chk("lit_red3_changes", 32'(n_changed), 32'd1);
        chk("lit_red3_raw",     32'(last_raw),  32'b001);

        frame(40, 40, 5, 50); frame(40, 40, 5, 50);
        frame(40, 5, 40, 50);
        chk("lit_blue_raw", 32'(last_raw), 32'b010);
        frame(40, 40, 5, 50); frame(40, 40, 5, 50);
        chk("lit_green_pending", 32'(color), 32'b001);
        frame(40, 40, 5, 50);
        chk("lit_green_color",   32'(color),     32'b100);
        chk("lit_green_changes", 32'(n_changed), 32'd2);

        frame(10, 10, 40, 50);
        chk("lit_tie_raw", 32'(last_raw), 32'b000);
        frame(30, 40, 50, 50);
        chk("lit_thresh_raw", 32'(last_raw), 32'b000);

        send(R, 10); send(G, 40); send(C, 50); idle(2);
        chk("lit_missing_err",   32'(n_fe),  32'd2);
        chk("lit_missing_color", 32'(color), 32'b100);
        frame(10, 30, 40, 50);
        chk("lit_after_err_raw", 32'(last_raw), 32'b001);

        frame(10, 30, 40, 3);
`ifdef CLEAR_GATE_EN
        chk("lit_dark_raw", 32'(last_raw), 32'b000);
`else
        chk("lit_dark_raw", 32'(last_raw), 32'b001);
`endif

        frame(23, 30, 40, 50);
        chk("lit_red_edge_in", 32'(last_raw), 32'b001);
        frame(24, 30, 40, 50);
        chk("lit_red_edge_out", 32'(last_raw), 32'b000);
        frame(40, 20, 30, 50);
        frame(40, 30, 18, 50);
        chk("lit_green_edge_in", 32'(last_raw), 32'b100);
        frame(40, 30, 19, 50);
        frame(10, 32'hFFFF_FFFF, 32'h8000_0000, 50);
        chk("lit_wide_raw", 32'(last_raw), 32'b001);

        send(R, 50); send(R, 10); send(B, 30); send(G, 40); send(C, 50);
        // Samples in the two busy cycles: red carries over, the clear is dropped.
        send(R, 12); send(C, 99);
        send(B, 30); send(G, 40); send(C, 50); idle(2);
        chk("lit_carry_raw", 32'(last_raw), 32'b001);

        frame(10, 10, 40, 50); frame(10, 10, 40, 50); frame(10, 10, 40, 50);
        chk("lit_none_color", 32'(color), 32'b000);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/color_classifier.md
Name: color_classifier

Overview:
- Downstream consumer of the colour-sensor frequency stage. Takes one count per filter channel (red, blue, green, clear) and assembles a full frame from them.
- Classifies each complete frame as red, blue, green or none.
- Publishes a debounced colour code to the rover steering logic. The code changes only after STABLE_N consecutive frames agree.

Parameters:
- CNT_W, 32, width of incoming channel counts
- RED_MAX, 24, red count must be strictly below this to qualify
- BLUE_MAX, 21, blue count must be strictly below this to qualify
- GREEN_MAX, 19, green count must be strictly below this to qualify
- STABLE_N, 3, consecutive identical raw classifications required to update color (1..15)
- CLEAR_MIN, 8, minimum clear count for a valid frame (used only with CLEAR_GATE_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- cnt_valid  in  1  one-cycle strobe: cnt_chan/cnt_value valid
- cnt_chan  in  2  filter code: 00 red, 01 blue, 11 green, 10 clear
- cnt_value  in  CNT_W  measured count for cnt_chan
- color  out  3  stable colour: 001 red, 010 blue, 100 green, 000 none
- color_changed  out  1  one-cycle pulse when color takes a new value
- raw_valid  out  1  one-cycle pulse when raw_class is updated
- raw_class  out  3  latest per-frame classification, same encoding as color
- frame_err  out  1  one-cycle pulse: clear sample arrived with a channel missing

Behaviour:
- Reset (async, rst=1): all outputs 0, channel regs 0, have-flags cleared, agree counter 0, candidate 000, FSM in COLLECT.
- FSM states: COLLECT, CLASSIFY, UPDATE.
- COLLECT: each cnt_valid stores cnt_value in the register for cnt_chan and sets that channel's have-flag.
  - A repeated channel within a frame overwrites the stored value; last value wins.
- Clear sample accepted at cycle T:
  - If R, B and G have-flags are all set, go to CLASSIFY.
  - Otherwise pulse frame_err at T+1, clear the have-flags, stay in COLLECT. raw/candidate/color are unchanged.
- CLASSIFY (cycle T+1):
  - Red wins if R<B, R<G and R<RED_MAX.
  - Blue wins if B<R, B<G and B<BLUE_MAX.
  - Green wins if G<R, G<B and G<GREEN_MAX.
  - Any tie, or a winner failing its threshold, gives 000.
  - All comparisons are unsigned, full CNT_W width.
  - raw_class is registered and raw_valid pulses at T+1.
- Agreement counting (same cycle as CLASSIFY):
  - If the raw result equals the candidate, the agree counter increments, saturating at STABLE_N.
  - Otherwise the candidate takes the raw result and the counter is set to 1.
- UPDATE (cycle T+2):
  - If agree counter == STABLE_N and candidate != color, color takes the candidate and color_changed pulses at T+2.
  - Clear the have-flags and return to COLLECT.
- cnt_valid during CLASSIFY/UPDATE:
  - Non-clear samples are accepted into the next frame; their have-flags are set after the clear performed in UPDATE.
  - A clear sample arriving in these states is dropped.
- None (000) is a legal stable colour: STABLE_N consecutive none frames drive color to 000.
- Frame-to-output latency is 2 cycles after the clear sample. Minimum frame spacing is 3 cycles.
- Reset mid-frame discards all partial state immediately; no pulses are emitted on reset release.

Optional Feature:
- Macro: CLEAR_GATE_EN.
- Defined: in CLASSIFY, a clear count < CLEAR_MIN forces the raw result to 000 (too dark / no target), regardless of R/B/G.
- Undefined: the clear count is stored but ignored; CLEAR_MIN is unused. Otherwise behaviour is identical.

Test Plan:
- Reset mid-frame: send R=10, B=30, assert rst for 1 cycle, then send G=5, clear=50 -> frame_err pulses (R/B missing); color stays 000, no raw_valid.
- Send 3 frames of R=10, B=30, G=40, clear=50 -> raw_valid each frame with raw_class=001. color stays 000 after frames 1 and 2. color=001 with a color_changed pulse exactly 2 cycles after the 3rd clear.
- Starting stable red: frames green, green, blue, green, green, green (G=5, others 40 for green; B=5, others 40 for blue) -> color changes to 100 only after the 3rd consecutive green following the blue; one color_changed pulse.
- Tie and threshold: frame R=10, B=10, G=40 -> raw_class=000. Frame R=30, B=40, G=50 (red fails RED_MAX=24) -> raw_class=000.
- Missing channel: R=10, G=40, clear=50 with no blue -> frame_err pulse at T+1; agree counter and color unchanged; next complete frame classifies normally.
- With CLEAR_GATE_EN: frame R=10, B=30, G=40, clear=3 -> raw_class=000. Same frame without the macro -> raw_class=001.
